// File: rtl/rcfg_mgr_if.sv
// Request, table-write and ICAP handshake bundle for rcfg_mgr.
// master: the requester / ICAP side; slave: the manager itself.
interface rcfg_mgr_if;
    // Request channel
    logic        req;
    logic [1:0]  req_id;
    logic        req_rdbk;
    logic        busy;
    logic        done;
    logic        err;
    // Bitstream table write port
    logic        tbl_we;
    logic [1:0]  tbl_idx;
    logic [31:0] tbl_baddr;
    logic [31:0] tbl_bsize;
    // ICAP interface
    logic        rc_start;
    logic        rc_bop;
    logic [31:0] rc_baddr;
    logic [31:0] rc_bsize;
    logic        rc_done;
    // Reconfigurable region control
    logic        rr_isolate;
    logic        rr_reset;

    modport master (
        output req, req_id, req_rdbk, tbl_we, tbl_idx, tbl_baddr, tbl_bsize, rc_done,
        input  busy, done, err, rc_start, rc_bop, rc_baddr, rc_bsize, rr_isolate, rr_reset
    );

    modport slave (
        input  req, req_id, req_rdbk, tbl_we, tbl_idx, tbl_baddr, tbl_bsize, rc_done,
        output busy, done, err, rc_start, rc_bop, rc_baddr, rc_bsize, rr_isolate, rr_reset
    );
endinterface

// File: rtl/rcfg_mgr.sv
// Partial-reconfiguration manager: looks up a bitstream in a 4-entry table, isolates the
// region, drives one ICAP transfer, resets the region and releases isolation.
// Optional feature: define RCFG_MGR_RDBK_EN to allow readback requests (req_rdbk=1);
// without it every operation is a configure and readback requests are rejected with err.
module rcfg_mgr #(
    parameter int unsigned ISO_CYCLES = 4,
    parameter int unsigned RST_CYCLES = 8
) (
    input logic       clk,
    input logic       rst,
    rcfg_mgr_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StIsolate,
        StStart,
        StWait,
        StReset,
        StRelease,
        StDone
    } state_e;

    // Counters load N-1 and the state exits when they reach zero, giving exactly N cycles.
    localparam logic [7:0] IsoLoad = 8'(ISO_CYCLES - 1);
    localparam logic [7:0] RstLoad = 8'(RST_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  iso_cnt_q, iso_cnt_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [31:0] tbl_baddr_q [4];
    logic [31:0] tbl_bsize_q [4];
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] bsize_q, bsize_d;
    logic        bop_q, bop_d;
    logic        err_q, err_d;

    logic        entry_empty;
    logic        rdbk_bad;
    logic        req_bop;
    logic        accept;
    logic        reject;

    // Request decode; reads the table registers, so a same-cycle write is not yet visible.
    always_comb begin
        entry_empty = (tbl_bsize_q[bus.req_id] == 32'd0);
`ifdef RCFG_MGR_RDBK_EN
        rdbk_bad    = 1'b0;
        req_bop     = ~bus.req_rdbk;
`else
        rdbk_bad    = bus.req_rdbk;
        req_bop     = 1'b1;
`endif
        accept      = (state_q == StIdle) && bus.req && !entry_empty && !rdbk_bad;
        reject      = (state_q == StIdle) && bus.req && (entry_empty || rdbk_bad);
    end

    // Bitstream table, writable in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                tbl_baddr_q[i] <= 32'd0;
                tbl_bsize_q[i] <= 32'd0;
            end
        end else if (bus.tbl_we) begin
            tbl_baddr_q[bus.tbl_idx] <= bus.tbl_baddr;
            tbl_bsize_q[bus.tbl_idx] <= bus.tbl_bsize;
        end
    end

    // Next-state, counter and latched-parameter logic.
    always_comb begin
        state_d   = state_q;
        iso_cnt_d = iso_cnt_q;
        rst_cnt_d = rst_cnt_q;
        baddr_d   = baddr_q;
        bsize_d   = bsize_q;
        bop_d     = bop_q;
        err_d     = reject;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    baddr_d   = tbl_baddr_q[bus.req_id];
                    bsize_d   = tbl_bsize_q[bus.req_id];
                    bop_d     = req_bop;
                    iso_cnt_d = IsoLoad;
                    state_d   = StIsolate;
                end
            end
            StIsolate: begin
                if (iso_cnt_q == 8'd0) begin
                    state_d = StStart;
                end else begin
                    iso_cnt_d = iso_cnt_q - 8'd1;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.rc_done) begin
                    rst_cnt_d = RstLoad;
                    state_d   = StReset;
                end
            end
            StReset: begin
                if (rst_cnt_q == 8'd0) begin
                    state_d = StRelease;
                end else begin
                    rst_cnt_d = rst_cnt_q - 8'd1;
                end
            end
            StRelease: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            iso_cnt_q <= 8'd0;
            rst_cnt_q <= 8'd0;
            baddr_q   <= 32'd0;
            bsize_q   <= 32'd0;
            bop_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            iso_cnt_q <= iso_cnt_d;
            rst_cnt_q <= rst_cnt_d;
            baddr_q   <= baddr_d;
            bsize_q   <= bsize_d;
            bop_q     <= bop_d;
            err_q     <= err_d;
        end
    end

    // Outputs are either registers or pure decodes of state_q.
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.err        = err_q;
    assign bus.rc_start   = (state_q == StStart);
    assign bus.rc_bop     = bop_q;
    assign bus.rc_baddr   = baddr_q;
    assign bus.rc_bsize   = bsize_q;
    assign bus.rr_reset   = (state_q == StReset);
    assign bus.rr_isolate = (state_q == StIsolate) || (state_q == StStart) ||
                            (state_q == StWait) || (state_q == StReset) ||
                            (state_q == StRelease);

endmodule

// File: tb/tb_rcfg_mgr.sv
// Scoreboard bench for rcfg_mgr: stimulus pushes the expected ICAP start / err outcome,
// a negedge monitor pops and compares whenever rc_start or err appears.
module tb_rcfg_mgr;

    localparam int unsigned IsoN = 4;
    localparam int unsigned RstN = 8;

    typedef struct packed {
        logic        is_err;
        logic [31:0] baddr;
        logic [31:0] bsize;
        logic        bop;
    } exp_t;

    logic clk;
    logic rst;
    rcfg_mgr_if bus ();

    rcfg_mgr #(
        .ISO_CYCLES(IsoN),
        .RST_CYCLES(RstN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errs   = 0;
    int   n_start  = 0;
    int   n_done   = 0;
    int   n_err    = 0;
    int   iso_len  = 0;
    int   rst_len  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            iso_len = 0;
            rst_len = 0;
        end else begin
            if (bus.rc_start) begin
                n_start++;
                check("iso_cycles_before_start", iso_len, IsoN);
                check("start_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    cur = e;
                    check("start_kind", e.is_err, 0);
                    check("rc_baddr", bus.rc_baddr, e.baddr);
                    check("rc_bsize", bus.rc_bsize, e.bsize);
                    check("rc_bop", bus.rc_bop, e.bop);
                end
            end
            if (bus.err) begin
                n_err++;
                check("err_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("err_kind", e.is_err, 1);
                end
            end
            if (bus.done) begin
                n_done++;
                check("done_isolate_low", bus.rr_isolate, 0);
                check("done_baddr_stable", bus.rc_baddr, cur.baddr);
                check("done_bsize_stable", bus.rc_bsize, cur.bsize);
                check("done_bop_stable", bus.rc_bop, cur.bop);
            end
            if (bus.rr_isolate) iso_len++;
            else iso_len = 0;
            if (bus.rr_reset) begin
                rst_len++;
            end else if (rst_len != 0) begin
                check("rr_reset_cycles", rst_len, RstN);
                rst_len = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input logic [1:0] idx, input logic [31:0] ba, input logic [31:0] bs);
        bus.tbl_we    = 1'b1;
        bus.tbl_idx   = idx;
        bus.tbl_baddr = ba;
        bus.tbl_bsize = bs;
        tick();
        bus.tbl_we    = 1'b0;
    endtask

    task automatic send_req(input logic [1:0] id, input logic rdbk);
        bus.req      = 1'b1;
        bus.req_id   = id;
        bus.req_rdbk = rdbk;
        tick();
        bus.req      = 1'b0;
        bus.req_rdbk = 1'b0;
    endtask

    task automatic push(input logic is_err, input logic [31:0] ba, input logic [31:0] bs,
                        input logic bop);
        exp_t e;
        e.is_err = is_err;
        e.baddr  = ba;
        e.bsize  = bs;
        e.bop    = bop;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(input int base);
        int k = 0;
        while (n_start == base && k < 60) begin
            tick();
            k++;
        end
        check("start_seen", n_start, base + 1);
    endtask

    task automatic wait_done(input int base);
        int k = 0;
        while (n_done == base && k < 60) begin
            tick();
            k++;
        end
        check("done_seen", n_done, base + 1);
    endtask

    task automatic pulse_done();
        bus.rc_done = 1'b1;
        tick();
        bus.rc_done = 1'b0;
    endtask

    // Waits for rc_start, answers rc_done 20 cycles later and waits for done.
    task automatic run_op();
        int s0;
        int d0;
        s0 = n_start;
        d0 = n_done;
        wait_start(s0);
        repeat (19) tick();
        pulse_done();
        wait_done(d0);
        check("busy_after_done", bus.busy, 0);
        check("one_start_per_op", n_start, s0 + 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_rc_start"}, bus.rc_start, 0);
        check({tag, "_rc_bop"}, bus.rc_bop, 0);
        check({tag, "_rc_baddr"}, bus.rc_baddr, 0);
        check({tag, "_rc_bsize"}, bus.rc_bsize, 0);
        check({tag, "_rr_isolate"}, bus.rr_isolate, 0);
        check({tag, "_rr_reset"}, bus.rr_reset, 0);
    endtask

    initial begin
        int s0;
        int d0;
        int e0;
        rst           = 1'b1;
        bus.req       = 1'b0;
        bus.req_id    = 2'd0;
        bus.req_rdbk  = 1'b0;
        bus.tbl_we    = 1'b0;
        bus.tbl_idx   = 2'd0;
        bus.tbl_baddr = 32'd0;
        bus.tbl_bsize = 32'd0;
        bus.rc_done   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Basic configure, with a table write mid-operation that must not disturb outputs.
        write_tbl(2'd2, 32'h100, 32'h40);
        push(1'b0, 32'h100, 32'h40, 1'b1);
        send_req(2'd2, 1'b0);
        write_tbl(2'd2, 32'h999, 32'h77);
        write_tbl(2'd2, 32'h100, 32'h40);
        run_op();

        // Empty entry rejected.
        s0 = n_start;
        e0 = n_err;
        push(1'b1, 32'd0, 32'd0, 1'b0);
        send_req(2'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("empty_busy_low", bus.busy, 0);
            tick();
        end
        check("empty_err_once", n_err, e0 + 1);
        check("empty_no_start", n_start, s0);

        // Same-cycle request and write to the same entry uses pre-write contents.
        write_tbl(2'd0, 32'h10, 32'h5);
        push(1'b0, 32'h10, 32'h5, 1'b1);
        bus.tbl_we    = 1'b1;
        bus.tbl_idx   = 2'd0;
        bus.tbl_baddr = 32'h20;
        bus.tbl_bsize = 32'h6;
        send_req(2'd0, 1'b0);
        bus.tbl_we    = 1'b0;
        run_op();
        push(1'b0, 32'h20, 32'h6, 1'b1);
        send_req(2'd0, 1'b0);
        run_op();

        // Stray rc_done in ISOLATE and req in WAIT are both ignored.
        s0 = n_start;
        d0 = n_done;
        e0 = n_err;
        push(1'b0, 32'h100, 32'h40, 1'b1);
        send_req(2'd2, 1'b0);
        tick();
        pulse_done();
        wait_start(s0);
        tick();
        send_req(2'd0, 1'b0);
        repeat (3) tick();
        check("wait_holds_busy", bus.busy, 1);
        check("wait_holds_no_reset", bus.rr_reset, 0);
        check("wait_holds_isolate", bus.rr_isolate, 1);
        pulse_done();
        wait_done(d0);
        repeat (2) tick();
        check("stray_one_start", n_start, s0 + 1);
        check("stray_one_done", n_done, d0 + 1);
        check("stray_no_err", n_err, e0);

        // Reset in WAIT clears everything, including the table.
        s0 = n_start;
        push(1'b0, 32'h100, 32'h40, 1'b1);
        send_req(2'd2, 1'b0);
        wait_start(s0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midop_reset");
        d0 = n_done;
        push(1'b1, 32'd0, 32'd0, 1'b0);
        send_req(2'd2, 1'b0);
        repeat (2) tick();
        push(1'b1, 32'd0, 32'd0, 1'b0);
        send_req(2'd0, 1'b0);
        repeat (3) tick();
        check("cleared_table_no_start", n_start, s0 + 1);
        check("aborted_op_no_done", n_done, d0);

        // Readback request.
        write_tbl(2'd3, 32'h300, 32'h80);
`ifdef RCFG_MGR_RDBK_EN
        push(1'b0, 32'h300, 32'h80, 1'b0);
        send_req(2'd3, 1'b1);
        run_op();
`else
        s0 = n_start;
        e0 = n_err;
        push(1'b1, 32'd0, 32'd0, 1'b0);
        send_req(2'd3, 1'b1);
        repeat (3) tick();
        check("rdbk_rejected_err", n_err, e0 + 1);
        check("rdbk_no_start", n_start, s0);
        check("rdbk_busy_low", bus.busy, 0);
`endif
        // A normal configure still works afterwards.
        push(1'b0, 32'h300, 32'h80, 1'b1);
        send_req(2'd3, 1'b0);
        run_op();

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
